// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 8-bit memory bus between master 0 (CPU) and
// master 1 (UART boot-loader / DMA). Owner-based arbitration with round-robin
// tie breaking; read responses are tagged back to the issuing master through
// a READ_LATENCY-deep tag pipeline.
// Optional feature: define ARB_BURST_LIMIT_EN to cap an owner at MAX_BURST
// consecutive beats while the other master is waiting.
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1,  // 1..3
  parameter int MAX_BURST    = 4
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       m0_req_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_addr_i,
  input  logic [7:0] m0_wdata_i,
  output logic       m0_gnt_o,
  output logic       m0_rvalid_o,
  output logic [7:0] m0_rdata_o,
  input  logic       m1_req_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m1_gnt_o,
  output logic       m1_rvalid_o,
  output logic [7:0] m1_rdata_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  input  logic [7:0] mem_rdata_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   last_owner_q, last_owner_d;

  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [READ_LATENCY-1:0] tag_id_q;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`endif

  // Owner-relative views of the request lines (only meaningful in OWNn).
  logic   own_id;
  logic   own_req;
  logic   oth_req;
  state_e oth_state;

  assign own_id    = (state_q == OWN1);
  assign own_req   = own_id ? m1_req_i : m0_req_i;
  assign oth_req   = own_id ? m0_req_i : m1_req_i;
  assign oth_state = own_id ? OWN0 : OWN1;

  // State, round-robin pointer and burst counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;  // master 0 wins the first tie
`ifdef ARB_BURST_LIMIT_EN
      beat_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
`ifdef ARB_BURST_LIMIT_EN
      beat_cnt_q   <= beat_cnt_d;
`endif
    end
  end

  // Next-state: arbitration from IDLE, release / handoff from OWNn.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
`ifdef ARB_BURST_LIMIT_EN
    beat_cnt_d   = beat_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) state_d = last_owner_q ? OWN0 : OWN1;
        else if (m0_req_i)        state_d = OWN0;
        else if (m1_req_i)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_req) begin
`ifdef ARB_BURST_LIMIT_EN
          // ">=" keeps the wait bounded even if the count saturated while
          // the other master was idle.
          if (oth_req && (beat_cnt_q >= CNT_W'(MAX_BURST - 1))) begin
            state_d      = oth_state;
            last_owner_d = own_id;
          end else if (beat_cnt_q != CNT_W'(MAX_BURST)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
`endif
        end else begin
          last_owner_d = own_id;
          state_d      = oth_req ? oth_state : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_BURST_LIMIT_EN
    if (state_d != state_q) beat_cnt_d = '0;
`endif
  end

  // Outputs: grant follows the owner's request combinationally; bus idles at 0.
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      OWN0: if (m0_req_i) begin
        m0_gnt_o    = 1'b1;
        mem_we_o    = m0_we_i;
        mem_addr_o  = m0_addr_i;
        mem_wdata_o = m0_wdata_i;
      end
      OWN1: if (m1_req_i) begin
        m1_gnt_o    = 1'b1;
        mem_we_o    = m1_we_i;
        mem_addr_o  = m1_addr_i;
        mem_wdata_o = m1_wdata_i;
      end
      default: ;
    endcase
  end

  logic read_beat;
  assign read_beat = (m0_gnt_o && !m0_we_i) || (m1_gnt_o && !m1_we_i);

  // Read-tag shift register: one slot per cycle of memory read latency.
  // NOTE: the tag pipeline is reset (unlike a data RAM) because a stale
  // valid bit would produce a spurious rvalid after reset is released.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= read_beat;
      tag_id_q[0]  <= m1_gnt_o;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  logic rsp_vld;
  logic rsp_id;
  assign rsp_vld = tag_vld_q[READ_LATENCY-1];
  assign rsp_id  = tag_id_q[READ_LATENCY-1];

  assign m0_rvalid_o = rsp_vld && !rsp_id;
  assign m1_rvalid_o = rsp_vld && rsp_id;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : 8'h00;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : 8'h00;

  assign busy_o = (state_q != IDLE) || (|tag_vld_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: two instances (read latency 1 and 2) share
// the same request stimulus. A transaction-level model predicts every output
// each cycle; directed scenarios add literal expectations on top.
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic       a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_busy;
  logic [7:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_busy;
  logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.READ_LATENCY(1), .MAX_BURST(MAXB)) u_a (
    .clk_i(clk), .reset_ni(reset_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
    .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(a_mem_rdata), .busy_o(a_busy));

  mem_bus_arbiter #(.READ_LATENCY(2), .MAX_BURST(MAXB)) u_b (
    .clk_i(clk), .reset_ni(reset_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(b_mem_rdata), .busy_o(b_busy));

  // Memory behind the bus: one storage array, one read pipe per latency.
  logic [7:0] mem [256];
  logic [7:0] rd_a, rd_b0, rd_b1;
  assign a_mem_rdata = rd_a;
  assign b_mem_rdata = rd_b1;

  always @(posedge clk) begin
    rd_a  <= mem[a_mem_addr];
    rd_b0 <= mem[b_mem_addr];
    rd_b1 <= rd_b0;
    if (a_mem_we) mem[a_mem_addr] <= a_mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       g0, g1, we;
    logic [7:0] addr, wdata;
    logic       rv0;
    logic [7:0] rd0;
    logic       rv1;
    logic [7:0] rd1;
    logic       busy;
  } out_t;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } rsp_t;

  out_t a_out, b_out;
  assign a_out = {a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_addr, a_mem_wdata,
                  a_m0_rvalid, a_m0_rdata, a_m1_rvalid, a_m1_rdata, a_busy};
  assign b_out = {b_m0_gnt, b_m1_gnt, b_mem_we, b_mem_addr, b_mem_wdata,
                  b_m0_rvalid, b_m0_rdata, b_m1_rvalid, b_m1_rdata, b_busy};

  logic [7:0] emem [256];
  rsp_t q_a[$], q_b[$];
  int   owner = -1;  // -1 idle, else owning master
  int   last  = 1;
  int   cnt   = 0;
  int   cyc   = 0;

  task automatic check_outs(input string tag, input out_t act, input out_t exp);
    check({tag, ".m0_gnt"},    act.g0,    exp.g0);
    check({tag, ".m1_gnt"},    act.g1,    exp.g1);
    check({tag, ".mem_we"},    act.we,    exp.we);
    check({tag, ".mem_addr"},  act.addr,  exp.addr);
    check({tag, ".mem_wdata"}, act.wdata, exp.wdata);
    check({tag, ".m0_rvalid"}, act.rv0,   exp.rv0);
    check({tag, ".m0_rdata"},  act.rd0,   exp.rd0);
    check({tag, ".m1_rvalid"}, act.rv1,   exp.rv1);
    check({tag, ".m1_rdata"},  act.rd1,   exp.rd1);
    check({tag, ".busy"},      act.busy,  exp.busy);
  endtask

  // Expected response view of one latency's outstanding-read queue.
  function automatic out_t add_rsp(input out_t base, input rsp_t q[$], input int now);
    out_t o = base;
    o.busy = base.busy || (q.size() > 0);
    if (q.size() > 0 && q[0].due == now) begin
      if (q[0].id) begin o.rv1 = 1'b1; o.rd1 = q[0].data; end
      else         begin o.rv0 = 1'b1; o.rd0 = q[0].data; end
    end
    return o;
  endfunction

  // Compare process: predict outputs for this cycle, compare, then advance.
  always @(negedge clk) begin
    out_t e;
    logic beat, bwe, oreq, xreq;
    logic [7:0] baddr, bdata;
    cyc++;
    if (!reset_n) begin
      owner = -1; last = 1; cnt = 0;
      q_a.delete(); q_b.delete();
    end
    e = '0;
    e.g0 = (owner == 0) && m0_req;
    e.g1 = (owner == 1) && m1_req;
    beat  = e.g0 || e.g1;
    bwe   = e.g0 ? m0_we    : m1_we;
    baddr = e.g0 ? m0_addr  : m1_addr;
    bdata = e.g0 ? m0_wdata : m1_wdata;
    if (beat) begin e.we = bwe; e.addr = baddr; e.wdata = bdata; end
    e.busy = (owner != -1);
    check_outs("A", a_out, add_rsp(e, q_a, cyc));
    check_outs("B", b_out, add_rsp(e, q_b, cyc));
    if (q_a.size() > 0 && q_a[0].due == cyc) void'(q_a.pop_front());
    if (q_b.size() > 0 && q_b[0].due == cyc) void'(q_b.pop_front());

    if (reset_n) begin
      if (beat && !bwe) begin
        q_a.push_back('{cyc + 1, e.g1, emem[baddr]});
        q_b.push_back('{cyc + 2, e.g1, emem[baddr]});
      end
      if (beat && bwe) emem[baddr] = bdata;
      if (owner < 0) begin
        if (m0_req && m1_req) owner = 1 - last;
        else if (m0_req)      owner = 0;
        else if (m1_req)      owner = 1;
        cnt = 0;
      end else begin
        oreq = owner ? m1_req : m0_req;
        xreq = owner ? m0_req : m1_req;
        if (oreq) begin
`ifdef ARB_BURST_LIMIT_EN
          if (xreq && cnt >= MAXB - 1) begin last = owner; owner = 1 - owner; cnt = 0; end
          else if (cnt < MAXB) cnt++;
`endif
        end else begin
          last  = owner;
          owner = xreq ? 1 - owner : -1;
          cnt   = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  int m0_cnt, first_m1_at;
  bit m1_done;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h39;
      emem[i] = 8'(i) ^ 8'h39;
    end
    reset_n = 0;
    idle_inputs();
    #2;
    check("reset.gnt", {a_m0_gnt, a_m1_gnt}, 0);
    check("reset.bus", {a_mem_we, a_mem_addr, a_mem_wdata}, 0);
    check("reset.busy", a_busy, 0);
    tick(); tick();
    reset_n = 1;
    tick();

    // Single write from IDLE
    m0_req = 1; m0_we = 1; m0_addr = 8'h20; m0_wdata = 8'hA5;
    #1 check("wr.c1_gnt", a_m0_gnt, 0);
    tick();
    check("wr.c2_gnt", a_m0_gnt, 1);
    check("wr.c2_we", a_mem_we, 1);
    check("wr.c2_addr", a_mem_addr, 8'h20);
    check("wr.c2_wdata", a_mem_wdata, 8'hA5);
    tick(); m0_req = 0; m0_we = 0;
    tick();
    check("wr.idle_busy", a_busy, 0);

    // Tagged read by master 1 (mem[0x05] = 0x3C)
    m1_req = 1; m1_we = 0; m1_addr = 8'h05;
    tick();
    check("rd.gnt", a_m1_gnt, 1);
    tick(); m1_req = 0;
    #1;
    check("rd.a_rvalid", a_m1_rvalid, 1);
    check("rd.a_rdata", a_m1_rdata, 8'h3C);
    check("rd.a_m0_rvalid", a_m0_rvalid, 0);
    check("rd.b_early", b_m1_rvalid, 0);
    tick();
    check("rd.b_rvalid", b_m1_rvalid, 1);
    check("rd.b_rdata", b_m1_rdata, 8'h3C);
    check("rd.a_done", a_m1_rvalid, 0);
    tick();

    // Tie after reset, then direct handoff
    pulse_reset();
    m0_req = 1; m0_we = 1; m0_addr = 8'h30; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 1; m1_addr = 8'h31; m1_wdata = 8'h22;
    tick();
    check("tie.m0_gnt", a_m0_gnt, 1);
    check("tie.m1_gnt", a_m1_gnt, 0);
    check("tie.addr", a_mem_addr, 8'h30);
    tick(); m0_req = 0;
    #1 check("tie.release_m1", a_m1_gnt, 0);
    tick();
    check("tie.handoff_m1", a_m1_gnt, 1);
    check("tie.handoff_addr", a_mem_addr, 8'h31);
    check("tie.handoff_wdata", a_mem_wdata, 8'h22);
    tick(); m1_req = 0;
    tick();

    // Read across handoff (mem[0x40] = 0x79)
    m0_req = 1; m0_we = 0; m0_addr = 8'h40;
    m1_req = 1; m1_we = 1; m1_addr = 8'h41; m1_wdata = 8'h77;
    tick();
    check("xh.m0_gnt", a_m0_gnt, 1);
    check("xh.rd_we", a_mem_we, 0);
    tick(); m0_req = 0;
    #1;
    check("xh.a_rvalid", a_m0_rvalid, 1);
    check("xh.a_rdata", a_m0_rdata, 8'h79);
    check("xh.release_we", a_mem_we, 0);
    tick();
    check("xh.m1_gnt", a_m1_gnt, 1);
    check("xh.m1_we", a_mem_we, 1);
    check("xh.b_rvalid", b_m0_rvalid, 1);
    check("xh.b_rdata", b_m0_rdata, 8'h79);
    check("xh.b_m1_rvalid", b_m1_rvalid, 0);
    tick(); idle_inputs();
    tick();

    // Reset while a read is outstanding
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    tick();
    check("rst.gnt", a_m0_gnt, 1);
    tick(); m0_req = 0; reset_n = 0;
    #1;
    check("rst.a_rvalid", a_m0_rvalid, 0);
    check("rst.b_rvalid", b_m0_rvalid, 0);
    check("rst.b_busy", b_busy, 0);
    check("rst.bus", {b_mem_we, b_mem_addr, b_mem_wdata, b_m0_gnt, b_m1_gnt}, 0);
    tick();
    check("rst.b_rvalid_due", b_m0_rvalid, 0);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.after_rvalid", {a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid}, 0);
    end

    // Burst: m0 wants 10 beats while m1 waits
    pulse_reset();
    m0_cnt = 0; m1_done = 0; first_m1_at = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      m0_req = (m0_cnt < 10); m0_we = 1;
      m0_addr = 8'(8'h80 + m0_cnt); m0_wdata = 8'(m0_cnt);
      m1_req = !m1_done; m1_we = 1; m1_addr = 8'h90; m1_wdata = 8'hEE;
      #1;
      if (a_m0_gnt) m0_cnt++;
      if (a_m1_gnt && !m1_done) begin m1_done = 1; first_m1_at = m0_cnt; end
      if (m0_cnt == 10 && m1_done) break;
    end
    check("burst.m0_total", m0_cnt, 10);
    check("burst.m1_served", m1_done, 1);
`ifdef ARB_BURST_LIMIT_EN
    check("burst.m0_before_m1", first_m1_at, MAXB);
`else
    check("burst.m0_before_m1", first_m1_at, 10);
`endif
    tick(); idle_inputs();
    tick(); tick(); tick();
    check("end.busy", {a_busy, b_busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
